rd_sched: RTL

Descriptor scheduler in front of the `rd_ctrl` packet reader. It queues packet descriptors (begin/end byte addresses in HPS memory) pushed by the CSR/descriptor source, validates each one, and starts one `rd_ctrl` transfer at a time. It drives `pkt_begin`/`pkt_end`/`rd_ctrl` and waits for `rd_ctrl_rdy` before issuing the next descriptor. It keeps sent/dropped counters for software.

---
 rtl/rd_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rd_sched.sv
// Descriptor scheduler: queues {begin,end} descriptors, validates them and starts one rd_ctrl transfer at a time.
// Optional WAIT watchdog is compiled in with `define RD_SCHED_TIMEOUT_EN.
module rd_sched #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned MAX_BYTES      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_begin,
  input  logic [31:0] desc_end,
  output logic        rd_ctrl,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  input  logic        rd_ctrl_rdy,
  output logic        busy,
  output logic [31:0] pkt_count,
  output logic [15:0] drop_count,
  output logic        err,
  input  logic        err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, GAP} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH-1:0][63:0]  mem_q;
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    ready_q;
  logic                    push, pop, load, inc_pkt, set_err;
  logic [31:0]             hold_b_q, hold_e_q;
  logic [31:0]             pkt_begin_q, pkt_end_q, pkt_count_q;
  logic [15:0]             drop_q;
  logic                    err_q;
  logic [31:0]             len;
  logic                    legal;
  logic                    wd_expired;

  // Ready is registered from the next count, so it only ever reflects the current occupancy.
  assign push  = desc_valid && ready_q;
  assign cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign len   = hold_e_q - hold_b_q;
  assign legal = (hold_e_q > hold_b_q) && (hold_b_q[1:0] == 2'b00) &&
                 (hold_e_q[1:0] == 2'b00) && (len <= MAX_BYTES);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {desc_begin, desc_end};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      hold_b_q    <= '0;
      hold_e_q    <= '0;
      pkt_begin_q <= '0;
      pkt_end_q   <= '0;
      pkt_count_q <= '0;
      drop_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != FULL_CNT);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q             <= rd_ptr_q + 1'b1;
        {hold_b_q, hold_e_q} <= mem_q[rd_ptr_q];
      end
      if (load) begin
        pkt_begin_q <= hold_b_q;
        pkt_end_q   <= hold_e_q;
      end
      if (inc_pkt) pkt_count_q <= pkt_count_q + 32'd1;
      if (set_err && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      // A new error outranks a simultaneous clear.
      if (set_err)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

`ifdef RD_SCHED_TIMEOUT_EN
  logic [31:0] wd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               wd_q <= '0;
    else if (state_q != WAIT) wd_q <= '0;
    else                      wd_q <= wd_q + 32'd1;
  end

  assign wd_expired = (wd_q == TIMEOUT_CYCLES - 1);
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    inc_pkt = 1'b0;
    set_err = 1'b0;
    unique case (state_q)
      IDLE:  if (enable && cnt_q != '0) begin
               pop     = 1'b1;
               state_d = CHECK;
             end
      CHECK: if (legal) begin
               load    = 1'b1;
               state_d = ISSUE;
             end else begin
               set_err = 1'b1;
               state_d = IDLE;
             end
      ISSUE: state_d = WAIT;
      // A done pulse coinciding with expiry is still a completed packet.
      WAIT:  if (rd_ctrl_rdy) begin
               inc_pkt = 1'b1;
               state_d = GAP;
             end else if (wd_expired) begin
               set_err = 1'b1;
               state_d = GAP;
             end
      GAP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign desc_ready = ready_q;
  assign rd_ctrl    = (state_q == ISSUE);
  assign pkt_begin  = pkt_begin_q;
  assign pkt_end    = pkt_end_q;
  assign busy       = (state_q != IDLE) || (cnt_q != '0);
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_q;
  assign err        = err_q;

endmodule
